// File: rtl/mac_result_fifo.sv
// mac_result_fifo: first-word-fall-through circular buffer that sits behind
// the signed 10x10 MAC. It captures each accumulator result qualified by
// in_valid and hands results to a consumer over a valid/ready handshake.
// The MAC cannot be stalled. When the buffer is full and the consumer does
// not pop, the incoming result is dropped and the sticky overflow flag is set.
module mac_result_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 20,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          overflow,
    input  logic          clr_overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers, occupancy and sticky flag state
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;
    logic           overflow_q, overflow_d;

    // Storage is never reset; the valid window is defined by count_q alone
    logic [W-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0] wr_en;

    logic push;
    logic pop;
    logic drop;
    logic is_empty;
    logic is_full;

    // Status decoded purely from the registered occupancy
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // Handshake qualification. A pop frees a slot on the same edge, so a
    // full buffer can still take a new result when the consumer is draining.
    always_comb begin
        pop  = !is_empty && out_ready;
        push = in_valid && (!is_full || pop);
        drop = in_valid && is_full && !pop;
    end

    // One-hot write enable per storage entry
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_q == AW'(gi));
        end
    endgenerate

    // Next pointer values; power-of-two depth makes the wrap a natural rollover
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    // Next occupancy: simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Sticky overflow: a drop on the same edge as a clear request wins
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write; only the entry addressed by wr_ptr_q is updated
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_q[i] <= in_data;
            end
        end
    end

    // Fall-through head read, forced to zero while the buffer is empty
    always_comb begin
        out_data = '0;
        if (!is_empty) begin
            out_data = mem_q[rd_ptr_q];
        end
    end

    assign out_valid = !is_empty;
    assign full      = is_full;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mac_result_fifo.sv
// Directed bench for mac_result_fifo: ordering, fill/drop, full with pop,
// streaming across pointer wraps, overflow clear priority and async reset.
module tb_mac_result_fifo;

    localparam int DEPTH = 8;
    localparam int W     = 20;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          overflow;
    logic          clr_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    mac_result_fifo #(.DEPTH(DEPTH), .W(W), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts, and reports mismatches
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %s: %0h", tag, obs);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = W'(first + i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        in_data      = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        tick();
        tick();
        check("rst_count",    32'(count), 0);
        check("rst_valid",    32'(out_valid), 0);
        check("rst_full",     32'(full), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_data",     32'(out_data), 0);
        reset = 1'b0;
        tick();

        // 1: basic order, values held until out_ready rises
        in_valid = 1'b1; in_data = 20'h00005; tick();
        in_data = 20'hFFFFD; tick();
        in_data = 20'h7FFFF; tick();
        in_valid = 1'b0;
        check("t1_count3", 32'(count), 3);
        check("t1_head_held", 32'(out_data), 32'h5);
        out_ready = 1'b1;
        check("t1_pop0", 32'(out_data), 32'h00005);
        tick();
        check("t1_pop1", 32'(out_data), 32'hFFFFD);
        tick();
        check("t1_pop2", 32'(out_data), 32'h7FFFF);
        tick();
        check("t1_empty_valid", 32'(out_valid), 0);
        check("t1_empty_count", 32'(count), 0);
        check("t1_empty_data",  32'(out_data), 0);
        out_ready = 1'b0;

        // 2: fill and drop
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            tick();
            if (i == 7) check("t2_notfull7", 32'(full), 0);
            if (i == 8) check("t2_full8", 32'(full), 1);
        end
        in_valid = 1'b0;
        check("t2_overflow", 32'(overflow), 1);
        check("t2_count", 32'(count), 8);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("t2_drain%0d", i), 32'(out_data), 32'(i));
            tick();
        end
        check("t2_drained", 32'(out_valid), 0);
        out_ready = 1'b0;
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        check("t2_clr", 32'(overflow), 0);

        // 3: full with simultaneous pop
        push_run(10, 8);
        check("t3_full", 32'(full), 1);
        in_valid = 1'b1; in_data = 20'd18; out_ready = 1'b1;
        check("t3_head10", 32'(out_data), 10);
        tick();
        in_valid = 1'b0;
        check("t3_count", 32'(count), 8);
        check("t3_fullkept", 32'(full), 1);
        check("t3_noovf", 32'(overflow), 0);
        for (int v = 11; v <= 18; v++) begin
            check($sformatf("t3_drain%0d", v), 32'(out_data), 32'(v));
            tick();
        end
        check("t3_empty", 32'(count), 0);
        out_ready = 1'b0;

        // 4: streaming through two pointer wraps
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = W'(100 + i);
            tick();
            check($sformatf("t4_data%0d", i), 32'(out_data), 32'(100 + i));
            check($sformatf("t4_cnt%0d", i), 32'(count), 1);
        end
        in_valid = 1'b0;
        tick();
        check("t4_empty", 32'(count), 0);
        out_ready = 1'b0;

        // 5: overflow clear priority
        push_run(200, 9);
        check("t5_ovf_set", 32'(overflow), 1);
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        check("t5_clr_alone", 32'(overflow), 0);
        clr_overflow = 1'b1; in_valid = 1'b1; in_data = 20'd209;
        tick();
        clr_overflow = 1'b0; in_valid = 1'b0;
        check("t5_drop_wins", 32'(overflow), 1);
        check("t5_count", 32'(count), 8);
        check("t5_head", 32'(out_data), 200);

        // 6: async reset mid-operation
        out_ready = 1'b1; tick(); tick(); tick(); out_ready = 1'b0;
        check("t6_count5", 32'(count), 5);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_full",  32'(full), 0);
        check("t6_rst_ovf",   32'(overflow), 0);
        tick();
        #2;
        reset = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 20'h80000;
        tick();
        in_valid = 1'b0;
        check("t6_data", 32'(out_data), 32'h80000);
        check("t6_count1", 32'(count), 1);
        check("t6_valid", 32'(out_valid), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_result_fifo.md
Name: mac_result_fifo

Overview:
Output buffer directly downstream of the 10x10 signed MAC. Captures every 20-bit signed accumulator result qualified by the MAC's valid_out and holds it in a circular FIFO. Presents results to the consumer (output controller or testbench sink) through a valid/ready handshake. The MAC has no backpressure input, so the FIFO absorbs consumer stalls, and results lost to a full FIFO are reported through a sticky flag.

Parameters:
- DEPTH, 8: number of entries; power of two, >= 2.
- W, 20: data width; matches the MAC output f.
- CW, $clog2(DEPTH)+1: width of the occupancy count.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_data, input, W: signed result; connect to MAC f.
- in_valid, input, 1: in_data is a new result this cycle; connect to MAC valid_out.
- out_data, output, W: signed head-of-FIFO value.
- out_valid, output, 1: out_data holds a valid entry.
- out_ready, input, 1: consumer accepts out_data this cycle.
- count, output, CW: current occupancy, 0..DEPTH.
- full, output, 1: count == DEPTH.
- overflow, output, 1: sticky; at least one result was dropped.
- clr_overflow, input, 1: synchronous clear of overflow.

Behaviour:
- Reset values (async, immediate on reset high): wr_ptr = 0, rd_ptr = 0, count = 0, out_valid = 0, full = 0, overflow = 0, out_data = 0. Storage contents are don't-care and are not reset.
- Outputs:
  - out_valid = (count != 0); full = (count == DEPTH). Both are decoded from registered count.
  - out_data = mem[rd_ptr] when out_valid = 1, else 0.
  - First-word-fall-through: no read latency.
- Push (push = in_valid && (!full || pop)):
  - write mem[wr_ptr] <= in_data.
  - wr_ptr advances mod DEPTH.
- Pop (pop = out_valid && out_ready): rd_ptr advances mod DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Latency: a value pushed into an empty FIFO at edge N appears on out_data with out_valid = 1 in the cycle after edge N. A pop and a push of the same value in one cycle is never possible.
- Full with simultaneous pop:
  - the push is accepted (slot freed this same edge).
  - count stays at DEPTH; full stays 1.
  - no drop, no overflow.
- Full without pop:
  - in_valid is dropped; mem, wr_ptr and count are unchanged.
  - overflow <= 1 at that edge.
- Overflow clearing:
  - overflow is cleared only by reset or by clr_overflow = 1.
  - if clr_overflow and a drop occur on the same edge, the drop wins and overflow = 1.
- out_ready while empty: ignored; no pointer change, no underflow.
- Pointer wrap: ptr == DEPTH-1 advances to 0. Data order is preserved across the wrap.
- Data: stored and returned bit-exact. No saturation or sign handling here; the MAC already saturates to 0x7FFFF / 0x80000.
- Reset mid-operation: all contents are abandoned. out_valid drops in the same cycle reset asserts. After reset deasserts, the first push lands at entry 0.
- Control: no FSM beyond the pointer/count datapath. Control is fully determined by count, push and pop.

Test Plan:
1. Basic order, DEPTH=8:
   - Stimulus: push 5, -3, 0x7FFFF (one per cycle) with out_ready = 0, then raise out_ready.
   - Required: count reaches 3; out_data shows 5, then 0xFFFFD, then 0x7FFFF, one per cycle; out_valid falls to 0 after the third pop; count = 0.
2. Fill and drop:
   - Stimulus: push 1..9 on consecutive cycles with out_ready = 0.
   - Required: full = 1 after the 8th push; the 9th value is dropped; overflow = 1; count = 8.
   - Then drain: outputs are 1..8 only.
3. Full with simultaneous pop:
   - Stimulus: fill with 10..17, then one cycle with in_valid = 1 (in_data = 18) and out_ready = 1.
   - Required: 10 popped, 18 accepted, count = 8, overflow = 0.
   - Full drain order: 11..18.
4. Wrap-around streaming:
   - Stimulus: out_ready = 1 constantly; push 20 values 100..119 back-to-back.
   - Required: each value appears one cycle after its push; count stays <= 1; order is intact across two pointer wraps.
5. Overflow clear priority:
   - Stimulus: set overflow via a drop; pulse clr_overflow alone.
   - Required: overflow = 0.
   - Stimulus: with the FIFO full and out_ready = 0, pulse clr_overflow and in_valid together.
   - Required: overflow = 1.
6. Async reset:
   - Stimulus: with count = 5, assert reset between clock edges.
   - Required: out_valid, count, full and overflow go to 0 immediately.
   - Stimulus: after release, push 0x80000.
   - Required: out_data = 0x80000 the next cycle; count = 1.
